// File: rtl/shift_register_sipo_rx.sv
// Serial-in parallel-out receiver: assembles WIDTH-bit words from a qualified serial
// stream and holds them behind a valid/ready handshake. Optional macro: SIPO_PARITY_CHECK_EN.
module shift_register_sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             parity_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SIPO_PARITY_CHECK_EN
    , PAR = 2'd2
`endif
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] shreg_r, shreg_s, shifted_s, first_s, word_s;
  logic             done_s;
`ifdef SIPO_PARITY_CHECK_EN
  logic             par_bit_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  // Shift direction decides whether the first bit ends up at the MSB or the LSB.
  assign shifted_s = MSB_FIRST ? {shreg_r[WIDTH-2:0], sin} : {sin, shreg_r[WIDTH-1:1]};
  assign first_s   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};
  assign busy      = (state_r != IDLE);

  // Next-state, bit counter, shift register and word-completion decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shreg_s = shreg_r;
    word_s  = shreg_r;
    done_s  = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
    par_bit_s = 1'b0;
`endif
    if (clr) begin
      state_s = IDLE;
      cnt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (sin_valid) begin
            shreg_s = first_s;
            cnt_s   = CW'(1);
            state_s = SHIFT;
          end else begin
            state_s = IDLE;
          end
        end
        SHIFT: begin
          if (sin_valid) begin
            shreg_s = shifted_s;
            if (cnt_r == LAST_IDX) begin
`ifdef SIPO_PARITY_CHECK_EN
              cnt_s   = CW'(WIDTH);
              state_s = PAR;
`else
              done_s  = 1'b1;
              word_s  = shifted_s;
              cnt_s   = {CW{1'b0}};
              state_s = IDLE;
`endif
            end else begin
              cnt_s = cnt_r + CW'(1);
            end
          end else begin
            state_s = SHIFT;
          end
        end
`ifdef SIPO_PARITY_CHECK_EN
        PAR: begin
          if (sin_valid) begin
            done_s    = 1'b1;
            word_s    = shreg_r;
            par_bit_s = sin;
            cnt_s     = {CW{1'b0}};
            state_s   = IDLE;
          end else begin
            state_s = PAR;
          end
        end
`endif
        default: begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Receive-side state registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      shreg_r <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      shreg_r <= shreg_s;
    end
  end

  // Output word register with handshake; a word completing into an unaccepted slot is dropped.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      dout       <= {WIDTH{1'b0}};
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (clr) begin
        overrun <= 1'b0;
      end else if (done_s && dout_valid && !dout_ready) begin
        overrun <= 1'b1;
      end
      if (done_s && (!dout_valid || dout_ready)) begin
        dout       <= word_s;
        dout_valid <= 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
        parity_err <= even_parity(word_s) ^ par_bit_s;
`else
        parity_err <= 1'b0;
`endif
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_register_sipo_rx.sv
// Scoreboard bench: two receivers (MSB-first and LSB-first) share one serial stream;
// expected words are queued when sent and compared when the consumer accepts them.
module tb_shift_register_sipo_rx;

`ifdef SIPO_PARITY_CHECK_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       Clk = 1'b0;
  logic       Rst, sin, sin_valid, clr, dout_ready;
  logic [3:0] dout_m, dout_l;
  logic       dv_m, dv_l, ov_m, ov_l, pe_m, pe_l, busy_m, busy_l;

  typedef struct {
    logic [3:0] m;
    logic [3:0] l;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  shift_register_sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .Clk(Clk), .Rst(Rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
    .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
    .overrun(ov_m), .parity_err(pe_m), .busy(busy_m));

  shift_register_sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .Clk(Clk), .Rst(Rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
    .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
    .overrun(ov_l), .parity_err(pe_l), .busy(busy_l));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] w);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] w, input bit par_ok);
    exp_t e;
    e.m = w;
    e.l = rev4(w);
`ifdef SIPO_PARITY_CHECK_EN
    e.pe = !par_ok;
`else
    e.pe = 1'b0;
`endif
    return e;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    sin       = b;
    sin_valid = 1'b1;
    step();
    sin       = 1'b0;
    sin_valid = 1'b0;
    repeat (gap) step();
  endtask

  // Sends w first-bit-first (w[3] first), then a parity bit when enabled.
  task automatic send_word(input logic [3:0] w, input int gap, input bit push,
                           input bit par_ok, input bit late_ready);
    if (push) sb.push_back(mk_exp(w, par_ok));
    for (int i = 0; i < NB; i++) begin
      logic b;
      b = (i < 4) ? w[3-i] : (par_ok ? ^w : ~^w);
      if (late_ready && i == NB - 1) dout_ready = 1'b1;
      send_bit(b, (i == NB - 1) ? 0 : gap);
    end
  endtask

  // Consumer side: every accepted word is checked against the oldest queued expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst && dv_m && dout_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_word", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("dout_msb_first", 32'(dout_m), 32'(e.m));
        check_eq("dout_lsb_first", 32'(dout_l), 32'(e.l));
        check_eq("valid_lsb_inst", 32'(dv_l), 32'd1);
        check_eq("parity_err", 32'(pe_m), 32'(e.pe));
      end
    end
  end

  initial begin
    Rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; clr = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("rst_dout", 32'(dout_m), 32'd0);
    check_eq("rst_valid", 32'(dv_m), 32'd0);
    check_eq("rst_overrun", 32'(ov_m), 32'd0);
    check_eq("rst_parity", 32'(pe_m), 32'd0);
    check_eq("rst_busy", 32'(busy_m), 32'd0);
    Rst = 1'b0;
    step();

    // Back-to-back bits 1,0,1,1 with the consumer always ready.
    dout_ready = 1'b1;
    sb.push_back(mk_exp(4'b1011, 1'b1));
    for (int i = 0; i < NB; i++) begin
      logic [4:0] bits;
      bits = {4'b1011, 1'b1};
      sin = bits[4-i];
      sin_valid = 1'b1;
      step();
      check_eq("s1_busy", 32'(busy_m), (i < NB - 1) ? 32'd1 : 32'd0);
      check_eq("s1_valid_timing", 32'(dv_m), (i == NB - 1) ? 32'd1 : 32'd0);
    end
    sin_valid = 1'b0;
    step();
    check_eq("s1_valid_pulse", 32'(dv_m), 32'd0);

    // Gaps between bits must leave partial state untouched.
    sb.push_back(mk_exp(4'b1011, 1'b1));
    send_bit(1'b1, 2);
    send_bit(1'b0, 2);
    check_eq("s2_busy_gap", 32'(busy_m), 32'd1);
    check_eq("s2_valid_gap", 32'(dv_m), 32'd0);
    send_bit(1'b1, 2);
    send_bit(1'b1, 0);
`ifdef SIPO_PARITY_CHECK_EN
    send_bit(1'b1, 0);
`endif
    step();

    // Stalled consumer: second word is dropped and flagged.
    dout_ready = 1'b0;
    send_word(4'b1011, 0, 1'b1, 1'b1, 1'b0);
    check_eq("s3_valid", 32'(dv_m), 32'd1);
    send_word(4'b0110, 0, 1'b0, 1'b1, 1'b0);
    check_eq("s3_overrun", 32'(ov_m), 32'd1);
    check_eq("s3_overrun_l", 32'(ov_l), 32'd1);
    check_eq("s3_dout_held", 32'(dout_m), 32'hB);
    dout_ready = 1'b1;
    step();
    check_eq("s3_valid_cleared", 32'(dv_m), 32'd0);
    check_eq("s3_overrun_sticky", 32'(ov_m), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("s3_clr_overrun", 32'(ov_m), 32'd0);

    // Completion on the same edge the pending word is accepted.
    dout_ready = 1'b0;
    send_word(4'b1011, 0, 1'b1, 1'b1, 1'b0);
    send_word(4'b0110, 0, 1'b1, 1'b1, 1'b1);
    check_eq("s4_valid_kept", 32'(dv_m), 32'd1);
    check_eq("s4_no_overrun", 32'(ov_m), 32'd0);
    step();
    check_eq("s4_valid_drop", 32'(dv_m), 32'd0);

    // Partial word aborted by clr (with a discarded bit on the clr edge).
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    check_eq("s5_busy_partial", 32'(busy_m), 32'd1);
    clr = 1'b1; sin = 1'b1; sin_valid = 1'b1;
    step();
    clr = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    check_eq("s5_clr_idle", 32'(busy_m), 32'd0);
    send_word(4'b0011, 0, 1'b1, 1'b1, 1'b0);
    step();

    // Partial word aborted by an asynchronous reset while a word is held.
    dout_ready = 1'b0;
    send_word(4'b1001, 0, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    #2 Rst = 1'b1;
    #1;
    check_eq("s5_rst_dout", 32'(dout_m), 32'd0);
    check_eq("s5_rst_valid", 32'(dv_m), 32'd0);
    check_eq("s5_rst_busy", 32'(busy_m), 32'd0);
    check_eq("s5_rst_busy_l", 32'(busy_l), 32'd0);
    Rst = 1'b0;
    dout_ready = 1'b1;
    step();
    send_word(4'b0011, 0, 1'b1, 1'b1, 1'b0);
    step();

`ifdef SIPO_PARITY_CHECK_EN
    send_word(4'b1011, 0, 1'b1, 1'b1, 1'b0);
    step();
    send_word(4'b1011, 0, 1'b1, 1'b0, 1'b0);
    step();
`endif

    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_register_sipo_rx.md
Name: shift_register_sipo_rx

Overview:
Serial-in parallel-out receiver that sits directly downstream of the PISO shift stage. It consumes the serial Q stream one bit per qualified clock and assembles WIDTH-bit words. Each completed word is presented on a held output register with a valid/ready handshake, so a slow consumer can apply backpressure. Overrun is flagged when a consumer stalls too long.

Parameters:
- WIDTH, 4, data bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit; connects to the upstream Q.
- sin_valid  input  1  sin is sampled on this edge when high; gaps are allowed.
- clr  input  1  synchronous abort: discard the partial word and clear overrun.
- dout  output  WIDTH  last completed word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout on an edge where dout_valid && dout_ready.
- overrun  output  1  sticky; set when a completed word is dropped.
- parity_err  output  1  parity result for the word in dout; see Optional Feature.
- busy  output  1  high while a partial word is held (state != IDLE).

Behaviour:
- Reset (async, Rst=1):
  - dout=0, dout_valid=0, overrun=0, parity_err=0, busy=0.
  - bit counter=0, shift register=0, state=IDLE.
  - Reset mid-word discards all partial data with no output.
- States: IDLE, SHIFT, PAR (PAR exists only with the macro).
- IDLE:
  - sin_valid=1 → capture bit 0, cnt=1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each sin_valid=1 edge captures one bit and does cnt++.
  - Edges without sin_valid hold all state.
  - On the edge that captures bit WIDTH-1:
    - without the macro → word complete, go to IDLE;
    - with the macro → go to PAR.
- Bit placement:
  - MSB_FIRST=1: shift left and insert at LSB, so after WIDTH bits the first bit is at the MSB.
  - MSB_FIRST=0: shift right and insert at MSB.
- Word complete (on the edge that samples the last required bit):
  - If dout_valid=0, or dout_valid && dout_ready on that same edge: dout ← assembled word, dout_valid=1. The word is visible the cycle after the last bit's edge (latency 1).
  - Otherwise the word is dropped, overrun ← 1 and dout stays unchanged.
- Handshake:
  - Accept with no new word completing → dout_valid ← 0 and dout holds its old value.
  - dout must not change while dout_valid=1 except on an accept edge.
- clr:
  - Edge with clr=1 → state=IDLE, cnt=0, overrun=0; any sin_valid bit on that edge is discarded.
  - dout and dout_valid are unaffected.
  - clr has priority over a completion on the same edge, so that word is lost without setting overrun.
- cnt width is $clog2(WIDTH+1); no wrap occurs, since cnt resets to 0 on every completion.
- busy = (state != IDLE).

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - After WIDTH data bits, one extra sin_valid bit is taken in state PAR as an even-parity bit.
  - Word completion happens on the parity-bit edge.
  - parity_err ← ^data ^ parity_bit, loaded together with dout.
  - A dropped word (overrun) does not update parity_err.
- Undefined:
  - No PAR state.
  - parity_err tied to 0.
  - Words are WIDTH bits only.

Test Plan:
- WIDTH=4, MSB_FIRST=1, sin_valid=1 with bits 1,0,1,1, dout_ready=1 → after the 4th edge dout=4'b1011 and dout_valid=1 for one cycle; busy high for 3 cycles.
- MSB_FIRST=0, same bits 1,0,1,1 with 2-cycle sin_valid gaps between bits → dout=4'b1101; no change to state or data during the gaps.
- dout_ready=0, send 1011 then 0110 → dout stays 1011 and overrun=1. Then assert dout_ready for 1 cycle → dout_valid=0; clr → overrun=0.
- Completion on the same edge that the previous word is accepted (1011 pending, 0110 finishing, dout_ready=1) → dout=0110, dout_valid stays 1, overrun=0.
- Send 2 bits, then clr (one case) or Rst pulse (other case), then send 0011 → dout=4'b0011 with no corruption from the partial word; after Rst, all outputs are 0 immediately.
- With SIPO_PARITY_CHECK_EN, send 1011 + parity 1 → parity_err=0. Send 1011 + parity 0 → parity_err=1. In both cases dout_valid rises only after the 5th bit.
